// File: rtl/uart_rx_sel_if.sv
// Receiver-side bundle: rate select and serial line in, byte and status strobes out.
// master is the receiver; slave is the pin driver plus the byte consumer.
interface uart_rx_sel_if;
    logic [1:0] baud_rate;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    modport master (
        input  baud_rate,
        input  rx,
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output parity_err
    );

    modport slave (
        output baud_rate,
        output rx,
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  parity_err
    );
endinterface

// File: rtl/uart_rx_sel.sv
// 16x-oversampled UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), byte strobed at the stop-bit centre.
// About 9.5 bit times from the start edge to the strobe; no backpressure, so the consumer must take rx_data on rx_valid.
module uart_rx_sel #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int OVS      = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_sel_if.master  bus
);

    localparam int DIV_2400  = CLK_FREQ / (2400  * OVS);
    localparam int DIV_4800  = CLK_FREQ / (4800  * OVS);
    localparam int DIV_9600  = CLK_FREQ / (9600  * OVS);
    localparam int DIV_19200 = CLK_FREQ / (19200 * OVS);
    localparam int DW        = $clog2(DIV_2400 + 1);

    localparam logic [3:0] TC_MID = 4'(OVS / 2 - 1);
    localparam logic [3:0] TC_END = 4'(OVS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic            rx_s1;
    logic            rx_s2;
    logic            rx_prev;
    logic [DW-1:0]   div_reg;
    logic [DW-1:0]   div_cnt;
    logic [3:0]      tick_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            par_bad;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            busy_q;
    logic            ferr_q;
    logic            perr_q;
    logic            tick;
    logic            fall;

    function automatic logic [DW-1:0] sel_div(input logic [1:0] b);
        case (b)
            2'b00:   sel_div = DW'(DIV_2400);
            2'b01:   sel_div = DW'(DIV_4800);
            2'b10:   sel_div = DW'(DIV_9600);
            default: sel_div = DW'(DIV_19200);
        endcase
    endfunction

    assign tick = (div_cnt == div_reg - 1'b1);
    // Start detection looks only at the fully synchronised copy of the line.
    assign fall = rx_prev & ~rx_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            div_reg  <= '0;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bad  <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            rx_s1   <= bus.rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;

            if (state == IDLE || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        busy_q   <= 1'b1;
                        tick_cnt <= '0;
                        par_bad  <= 1'b0;
                        div_reg  <= sel_div(bus.baud_rate);
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == TC_MID) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            if (!rx_s2) begin
                                state <= DATA;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == TC_END) begin
                            tick_cnt       <= '0;
                            shift[bit_idx] <= rx_s2;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (tick_cnt == TC_END) begin
                            tick_cnt <= '0;
                            // Even parity: data bits plus parity bit must hold an even count of ones.
                            par_bad  <= rx_s2 ^ (^shift);
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == TC_END) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            busy_q   <= 1'b0;
                            ferr_q   <= ~rx_s2;
                            perr_q   <= par_bad;
                            if (rx_s2 && !par_bad) begin
                                data_q  <= shift;
                                valid_q <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.rx_busy    = busy_q;
    assign bus.frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sel.sv
// Bench for uart_rx_sel: a serial driver pushes the expected outcome of each frame and a monitor
// pops and compares on every strobe; run at CLK_FREQ=1_843_200 so DIV is 48/24/12/6.
module tb_uart_rx_sel;
    localparam int CLK = 1_843_200;

    logic clk;
    logic reset;
    uart_rx_sel_if bus ();

    uart_rx_sel #(.CLK_FREQ(CLK), .OVS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       v;
        logic       fe;
        logic       pe;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         busy_rise_cyc = 0;
    int         valid_cyc = 0;
    logic [7:0] model_last = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at cyc %0d", name, got, want, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int bit_period(input int rate);
        int baud;
        case (rate)
            0:       baud = 2400;
            1:       baud = 4800;
            2:       baud = 9600;
            default: baud = 19200;
        endcase
        return 16 * (CLK / (baud * 16));
    endfunction

    // One complete frame on the pin; the expected receiver reaction is queued first.
    task automatic send_frame(input logic [7:0] d, input int rate, input logic stop, input logic pbit);
        exp_t e;
        int   bp;
        bp   = bit_period(rate);
        e.d  = d;
        e.fe = ~stop;
`ifdef UART_RX_PARITY_EN
        e.pe = (^d) ^ pbit;
`else
        e.pe = 1'b0;
`endif
        e.v  = ~e.fe & ~e.pe;
        exp_q.push_back(e);
        bus.rx = 1'b0;
        cycles(bp);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            cycles(bp);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = pbit;
        cycles(bp);
`else
        if (pbit) begin
            bus.rx = 1'b1;
        end
`endif
        bus.rx = stop;
        cycles(bp);
    endtask

    task automatic idle_gap(input int rate, input int nbits);
        bus.rx = 1'b1;
        cycles(bit_period(rate) * nbits);
    endtask

    // Monitor: pops one expectation per strobe and checks rx_data holds between good frames.
    initial begin
        logic [2:0] st;
        logic [2:0] prev_st;
        logic       prev_busy;
        exp_t       e;
        prev_st   = 3'b000;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            st = {bus.rx_valid, bus.frame_err, bus.parity_err};
            if (st != 3'b000) begin
                chk("strobe_single_cycle", {29'd0, prev_st}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {29'd0, st}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", {29'd0, st}, {29'd0, e.v, e.fe, e.pe});
                    chk("rx_data_at_strobe", {24'd0, bus.rx_data}, {24'd0, (e.v ? e.d : model_last)});
                    if (e.v) begin
                        model_last = e.d;
                        valid_cyc  = cyc;
                    end
                end
            end else begin
                chk("rx_data_hold", {24'd0, bus.rx_data}, {24'd0, model_last});
            end
            if (bus.rx_busy && !prev_busy) begin
                busy_rise_cyc = cyc;
            end
            prev_st   = st;
            prev_busy = bus.rx_busy;
        end
    end

    initial begin
        #(10 * 150_000);
        $display("FAIL watchdog cycles=%0d limit=150000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         rate;
        logic       stop;
        logic       pbit;

        reset         = 1'b0;
        bus.rx        = 1'b1;
        bus.baud_rate = 2'b10;

        // Reset held with a toggling line.
        for (int i = 0; i < 20; i++) begin
            bus.rx = i[0];
            cycles(1);
        end
        chk("reset_outputs", {20'd0, bus.rx_data, bus.rx_valid, bus.rx_busy, bus.frame_err, bus.parity_err}, 32'd0);
        bus.rx = 1'b1;
        cycles(2);
        reset = 1'b1;
        cycles(30);
        chk("post_reset_outputs", {20'd0, bus.rx_data, bus.rx_valid, bus.rx_busy, bus.frame_err, bus.parity_err}, 32'd0);

        // Single byte at 9600 with latency from detected start edge to strobe.
        bus.baud_rate = 2'b10;
        cycles(2);
        send_frame(8'hA5, 2, 1'b1, ^8'hA5);
        idle_gap(2, 2);
        checks++;
        if ((valid_cyc - busy_rise_cyc) < 1822 || (valid_cyc - busy_rise_cyc) > 1826) begin
            failures++;
            $display("FAIL latency_9600 got=%0d want=1824+-2", valid_cyc - busy_rise_cyc);
        end

        // Same byte at all four rates, rate switched while idle.
        for (int r = 0; r < 4; r++) begin
            bus.baud_rate = 2'(r);
            cycles(2);
            send_frame(8'h3C, r, 1'b1, ^8'h3C);
            idle_gap(r, 2);
        end

        // Rate select changed mid-frame must not disturb the frame in flight.
        bus.baud_rate = 2'b10;
        cycles(2);
        fork
            send_frame(8'h3C, 2, 1'b1, ^8'h3C);
            begin
                cycles(bit_period(2) * 3);
                bus.baud_rate = 2'b00;
            end
        join
        idle_gap(2, 2);
        bus.baud_rate = 2'b10;
        cycles(2);

        // Stop bit low, then a stuck-low line for three frame times.
        send_frame(8'h55, 2, 1'b0, ^8'h55);
        bus.rx = 1'b0;
        cycles(bit_period(2) * 30);
        chk("busy_while_stuck_low", {31'd0, bus.rx_busy}, 32'd0);
        idle_gap(2, 2);

        // Short low glitch is rejected as a false start.
        bus.rx = 1'b0;
        cycles(20);
        chk("busy_on_glitch", {31'd0, bus.rx_busy}, 32'd1);
        cycles(28);
        bus.rx = 1'b1;
        cycles(80);
        chk("busy_after_glitch", {31'd0, bus.rx_busy}, 32'd0);
        idle_gap(2, 2);

        // Reset in the middle of bit 4 aborts the frame without a strobe.
        d = 8'hF0;
        bus.rx = 1'b0;
        cycles(bit_period(2));
        for (int i = 0; i < 4; i++) begin
            bus.rx = d[i];
            cycles(bit_period(2));
        end
        bus.rx = d[4];
        cycles(bit_period(2) / 2);
        chk("busy_mid_frame", {31'd0, bus.rx_busy}, 32'd1);
        reset      = 1'b0;
        model_last = 8'h00;
        #1;
        chk("busy_at_reset", {29'd0, bus.rx_busy, bus.rx_valid, bus.frame_err}, 32'd0);
        bus.rx = 1'b1;
        cycles(5);
        reset = 1'b1;
        idle_gap(2, 12);
        send_frame(8'h81, 2, 1'b1, ^8'h81);
        idle_gap(2, 2);

        // Back-to-back frames with no idle gap.
        bus.baud_rate = 2'b11;
        cycles(2);
        send_frame(8'hC3, 3, 1'b1, ^8'hC3);
        send_frame(8'h18, 3, 1'b1, ^8'h18);
        idle_gap(3, 2);

`ifdef UART_RX_PARITY_EN
        bus.baud_rate = 2'b10;
        cycles(2);
        send_frame(8'h07, 2, 1'b1, 1'b1);
        idle_gap(2, 2);
        send_frame(8'h07, 2, 1'b1, 1'b0);
        idle_gap(2, 2);
        send_frame(8'h07, 2, 1'b0, 1'b0);
        idle_gap(2, 2);
`endif

        // Randomised frames: random byte, rate, occasional bad stop or parity bit.
        for (int k = 0; k < 8; k++) begin
            d    = 8'($urandom);
            rate = $urandom_range(1, 3);
            stop = ($urandom_range(0, 3) != 0);
            pbit = (^d) ^ ($urandom_range(0, 3) == 0);
            bus.baud_rate = 2'(rate);
            cycles(2);
            send_frame(d, rate, stop, pbit);
            idle_gap(rate, 2);
        end

        cycles(100);
        chk("pending_expectations", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_sel.md
Name: uart_rx_sel

Overview:
- UART receiver with selectable baud rate. It is the receive-side counterpart of the baud_gen transmit clocking.
- Samples an asynchronous serial line using 16x oversampling derived from the system clock.
- Assembles 8N1 frames (8E1 with the optional feature) and presents each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the byte-level consumer (command parser or FIFO).

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- OVS, 16, oversampling ticks per bit. Fixed at 16; the bit-centre logic depends on it.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted (0) clears all state.
- baud_rate  input  2  rate select: 00=2400, 01=4800, 10=9600, 11=19200 baud.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last received byte, LSB received first.
- rx_valid  output  1  one-cycle pulse when rx_data updates with a good frame.
- rx_busy  output  1  high from start-bit detect until the frame ends.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle pulse on parity mismatch (see Optional Feature).

Behaviour:
- Reset values:
  - rx_data=0x00; rx_valid=0; rx_busy=0; frame_err=0; parity_err=0.
  - FSM in IDLE; divider and counters at 0; synchronizer flops at 1.
- Input sync: rx passes through 2 flops before use. Latency from pin to FSM is 2 clk.
- Tick generator:
  - Divisor DIV = CLK_FREQ/(baud*16), integer truncation.
  - Counter counts 0..DIV-1; tick is a 1-cycle pulse when the counter reaches DIV-1.
  - The counter is held at 0 in IDLE and restarts at start detect.
  - baud_rate is latched into the divisor on the IDLE->START transition. Changes mid-frame are ignored until the next frame.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
  - IDLE: on a synced 1->0 transition of rx, go to START, set rx_busy=1, clear tick_cnt.
  - START: count ticks. At tick 7 (bit centre), if rx=0, go to DATA with tick_cnt=0 and bit_idx=0. If rx=1, it is a false start: return to IDLE, rx_busy=0, no strobe.
  - DATA: at every 16th tick (centre), shift rx into bit position bit_idx. After bit_idx=7, go to PARITY (feature) or STOP.
  - PARITY: sample at centre, compare against even parity of the 8 data bits, hold the result, go to STOP.
  - STOP: sample at centre.
    - If stop=1 and no parity error: rx_data<=shifted byte and rx_valid=1 for 1 cycle.
    - If stop=0: frame_err=1 for 1 cycle, rx_data unchanged, no rx_valid.
    - If a parity error occurred (stop=1): parity_err=1 for 1 cycle, rx_data unchanged, no rx_valid.
    - If stop=0 and a parity error occurred, both error pulses assert together.
    - In all cases return to IDLE and set rx_busy=0 in the same cycle.
- Back-to-back frames: IDLE re-arms immediately, so a start edge after the stop-bit centre is accepted.
- Break/stuck-low line: after a frame_err, no new frame starts until rx returns high and falls again (edge detect).
- Reset mid-frame: all state returns to reset values immediately, with no partial strobe.
- rx_valid, frame_err and parity_err are never high for more than 1 consecutive cycle.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: the frame is 8E1. The PARITY state is compiled in and parity_err is driven as above.
- Undefined: the frame is 8N1. There is no PARITY state, STOP follows bit 7 directly, and parity_err is tied to 0.

Test Plan:
- All scenarios use CLK_FREQ=1_843_200, which gives DIV=48/24/12/6 for 2400/4800/9600/19200 baud.
1. Hold reset=0 for 20 clk with rx toggling -> all outputs 0, no strobes; release -> outputs stay at 0 while rx=1.
2. baud_rate=2'b10, send 0xA5 8N1 at 9600 -> rx_data=0xA5 and exactly one rx_valid pulse. The pulse lands about 12*16*9.5 = 1824 clk after the start edge, ±2 clk.
3. Send 0x3C at each of the four rates, with baud_rate switched to the matching value while idle -> 0x3C received 4 times, no errors. Additionally, change baud_rate mid-frame -> the current byte is still received correctly.
4. Send 0x55 with stop bit forced 0 -> frame_err pulses once, rx_valid stays 0, rx_data keeps its previous value. Then hold rx low for 3 frame times and release -> no further strobes.
5. Low glitch on rx lasting 4 ticks (48 clk at 9600) -> rx_busy rises then falls by tick 7, with no strobes. Separately, assert reset during bit 4 of a frame -> rx_busy=0 at once and no strobe; the next clean frame 0x81 is received.
6. With UART_RX_PARITY_EN: send 0x07 with parity bit 1 (correct) -> rx_valid. Send it again with parity bit 0 -> parity_err pulses once and rx_valid stays 0.
